// File: rtl/ref_ctrl_pkg.sv
// Shared refresh-controller definitions: refresh memory depth and the address
// type used by the refresh memory, the scheduler and the address sequencer.
package ref_ctrl_pkg;

    localparam int REF_MEM_ENTRIES = 8;
    localparam int REF_MEM_ADDR_W  = (REF_MEM_ENTRIES > 1) ? $clog2(REF_MEM_ENTRIES) : 1;

    typedef logic [REF_MEM_ADDR_W-1:0] ref_mem_addr_t;

endpackage : ref_ctrl_pkg

// File: rtl/ref_mem_counter.sv
// Refresh memory address sequencer: steps one entry per completed refresh and
// pulses cycle_done on the edge that wraps the pointer back to entry 0.
module ref_mem_counter
    import ref_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = REF_MEM_ENTRIES,
    parameter int ADDR_W      = REF_MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              any_ref_done,
    output logic [ADDR_W-1:0] ref_mem_addr_o,
    output logic              cycle_done
);

    // One extra bit so NUM_ENTRIES == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] L_WRAP_AT = (ADDR_W+1)'(NUM_ENTRIES);

    logic [ADDR_W-1:0] r_addr;
    logic              r_cycle_done;

    logic [ADDR_W:0]   w_addr_inc;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_addr_next;

    always_comb begin
        w_addr_inc  = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
        w_wrap      = any_ref_done && (w_addr_inc == L_WRAP_AT);
        w_addr_next = r_addr;
        if (w_wrap) begin
            w_addr_next = '0;
        end else if (any_ref_done) begin
            w_addr_next = w_addr_inc[ADDR_W-1:0];
        end
    end

    // NOTE: state uses non-blocking assignments and clears on the asynchronous
    // reset edge, so outputs drop without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_addr       <= w_addr_next;
            r_cycle_done <= w_wrap;
        end
    end

    assign ref_mem_addr_o = r_addr;
    assign cycle_done     = r_cycle_done;

    a_no_x_input : assert property (@(posedge clk) disable iff (!rst)
        !$isunknown(any_ref_done));

    a_addr_range : assert property (@(posedge clk) disable iff (!rst)
        32'(r_addr) < NUM_ENTRIES);

    a_done_at_zero : assert property (@(posedge clk) disable iff (!rst)
        r_cycle_done |-> (r_addr == '0));

    a_done_single : assert property (@(posedge clk) disable iff (!rst)
        r_cycle_done |=> !r_cycle_done);

endmodule : ref_mem_counter

// File: tb/tb_ref_mem_counter.sv
// Self-checking bench for ref_mem_counter: an 8-entry and a 5-entry instance
// share one stimulus stream; expected outputs go through a scoreboard queue.
module tb_ref_mem_counter;

    logic       clk;
    logic       rst;
    logic       any_ref_done;
    logic [2:0] addr8;
    logic       cd8;
    logic [2:0] addr5;
    logic       cd5;

    typedef struct {
        int addr8;
        bit cd8;
        int addr5;
        bit cd5;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int m_addr8  = 0;
    int m_addr5  = 0;
    int cd_cnt8  = 0;
    int cd_cnt5  = 0;
    int cyc      = 0;

    ref_mem_counter #(.NUM_ENTRIES(8), .ADDR_W(3)) dut8 (
        .clk            (clk),
        .rst            (rst),
        .any_ref_done   (any_ref_done),
        .ref_mem_addr_o (addr8),
        .cycle_done     (cd8)
    );

    ref_mem_counter #(.NUM_ENTRIES(5), .ADDR_W(3)) dut5 (
        .clk            (clk),
        .rst            (rst),
        .any_ref_done   (any_ref_done),
        .ref_mem_addr_o (addr5),
        .cycle_done     (cd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_addr8 = 0;
        m_addr5 = 0;
    endfunction

    // Drive one cycle of stimulus, predict both instances, then compare.
    task automatic step(input logic d);
        exp_t e;
        exp_t got;
        @(negedge clk);
        any_ref_done = d;
        e.cd8 = d && (m_addr8 == 7);
        e.cd5 = d && (m_addr5 == 4);
        if (d) begin
            m_addr8 = (m_addr8 == 7) ? 0 : m_addr8 + 1;
            m_addr5 = (m_addr5 == 4) ? 0 : m_addr5 + 1;
        end
        e.addr8 = m_addr8;
        e.addr5 = m_addr5;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        check("addr8", {29'd0, addr8}, got.addr8);
        check("cd8",   {31'd0, cd8},   {31'd0, got.cd8});
        check("addr5", {29'd0, addr5}, got.addr5);
        check("cd5",   {31'd0, cd5},   {31'd0, got.cd5});
        if (cd8 === 1'b1) cd_cnt8++;
        if (cd5 === 1'b1) cd_cnt5++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        any_ref_done = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_addr8", {29'd0, addr8}, 0);
        check("rst_addr5", {29'd0, addr5}, 0);
        @(negedge clk);
        check("rst_hold_addr8", {29'd0, addr8}, 0);
        check("rst_hold_cd8",   {31'd0, cd8},   0);
        rst = 1'b1;
    endtask

    initial begin
        int seq8 [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        int seq5 [5] = '{1, 2, 3, 4, 0};
        int cd_at[$];

        rst          = 1'b0;
        any_ref_done = 1'b0;

        // Reset before any clock edge, then one clocked cycle in reset.
        #1;
        check("rst0_addr8", {29'd0, addr8}, 0);
        check("rst0_cd8",   {31'd0, cd8},   0);
        check("rst0_addr5", {29'd0, addr5}, 0);
        check("rst0_cd5",   {31'd0, cd5},   0);
        @(negedge clk);
        check("rst1_addr8", {29'd0, addr8}, 0);
        check("rst1_cd8",   {31'd0, cd8},   0);
        rst = 1'b1;
        step(1'b0);
        check("exit_cd8", {31'd0, cd8}, 0);

        // Isolated pulses walk the 8-entry pointer through a full pass.
        cd_cnt8 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("single_seq",  {29'd0, addr8}, seq8[i]);
            check("single_done", {31'd0, cd8},   (i == 7) ? 1 : 0);
            for (int j = 0; j < 10; j++) step(1'b0);
        end
        check("single_cd_count", cd_cnt8, 1);

        // Long run of isolated pulses from address 0.
        cd_cnt8 = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check("long_addr", {29'd0, addr8}, 4);
        check("long_cd_count", cd_cnt8, 12);

        // Reach 5, then reset between clock edges.
        step(1'b1);
        check("pre_rst_addr", {29'd0, addr8}, 5);
        @(negedge clk);
        any_ref_done = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_addr8", {29'd0, addr8}, 0);
        check("async_cd8",   {31'd0, cd8},   0);
        check("async_addr5", {29'd0, addr5}, 0);
        @(negedge clk);
        check("async_hold_addr8", {29'd0, addr8}, 0);
        rst = 1'b1;
        step(1'b1);
        check("resume_addr8", {29'd0, addr8}, 1);

        // Continuous high from address 0: two wraps 8 cycles apart.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1);
            check("cont_addr", {29'd0, addr8}, (i + 1) % 8);
            if (cd8 === 1'b1) cd_at.push_back(i);
        end
        step(1'b0);
        check("cont_cd_count", cd_at.size(), 2);
        if (cd_at.size() == 2) begin
            check("cont_cd_first", cd_at[0], 7);
            check("cont_cd_gap",   cd_at[1] - cd_at[0], 8);
        end

        // Non-power-of-two depth: 5 entries on a 3-bit address.
        apply_reset();
        cd_cnt5 = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("np2_seq",   {29'd0, addr5}, seq5[i]);
            check("np2_range", {31'd0, (addr5 < 3'd5)}, 1);
            step(1'b0);
        end
        check("np2_cd_count", cd_cnt5, 1);

        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ref_mem_counter
